// File: rtl/tmr_lockstep_controller.sv
// Lockstep supervisor for three replicated cores: bitwise 2-of-3 voting of the
// data-memory request and PC, per-lane fault tracking and restart sequencing.
module tmr_lockstep_controller #(
    parameter int FAULT_LIMIT   = 3,
    parameter int RESYNC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [31:0] pc_a,
    input  logic [31:0] pc_b,
    input  logic [31:0] pc_c,
    input  logic        memwrite_a,
    input  logic        memwrite_b,
    input  logic        memwrite_c,
    input  logic [31:0] addr_a,
    input  logic [31:0] addr_b,
    input  logic [31:0] addr_c,
    input  logic [31:0] wdata_a,
    input  logic [31:0] wdata_b,
    input  logic [31:0] wdata_c,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc_voted,
    output logic        core_rst_n,
    output logic        resync,
    output logic        no_majority,
    output logic [2:0]  fault_flags,
    output logic [7:0]  err_count
);

    localparam logic [3:0] LIMIT_M1  = 4'(FAULT_LIMIT - 1);
    localparam logic [7:0] HOLD_INIT = 8'(RESYNC_CYCLES - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_RESYNC = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  miss_cnt_q [3];
    logic [3:0]  miss_cnt_d [3];
    logic [2:0]  fault_flags_q, fault_flags_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        core_rst_n_q, core_rst_n_d;

    logic [31:0] pc_l    [3];
    logic [31:0] addr_l  [3];
    logic [31:0] wdata_l [3];
    logic        we_l    [3];
    logic [96:0] lane_vec [3];
    logic [96:0] voted_vec;
    logic [2:0]  lane_mis;
    logic [2:0]  limit_hit;
    logic        vote_we;
    logic        trigger;

    assign pc_l    = '{pc_a, pc_b, pc_c};
    assign addr_l  = '{addr_a, addr_b, addr_c};
    assign wdata_l = '{wdata_a, wdata_b, wdata_c};
    assign we_l    = '{memwrite_a, memwrite_b, memwrite_c};

    assign pc_voted  = (pc_a & pc_b) | (pc_a & pc_c) | (pc_b & pc_c);
    assign mem_addr  = (addr_a & addr_b) | (addr_a & addr_c) | (addr_b & addr_c);
    assign mem_wdata = (wdata_a & wdata_b) | (wdata_a & wdata_c) | (wdata_b & wdata_c);
    assign vote_we   = (memwrite_a & memwrite_b) | (memwrite_a & memwrite_c) | (memwrite_b & memwrite_c);

    // Store data only takes part in the comparison when the vote says it is a store.
    assign voted_vec = {pc_voted, vote_we, mem_addr, vote_we ? mem_wdata : 32'h0};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_vec[gi]  = {pc_l[gi], we_l[gi], addr_l[gi], vote_we ? wdata_l[gi] : 32'h0};
            assign lane_mis[gi]  = (lane_vec[gi] != voted_vec);
            assign limit_hit[gi] = lane_mis[gi] && (miss_cnt_q[gi] == LIMIT_M1);
        end
    endgenerate

    assign no_majority = (lane_vec[0] != lane_vec[1]) &&
                         (lane_vec[0] != lane_vec[2]) &&
                         (lane_vec[1] != lane_vec[2]);
    assign trigger = no_majority || (|limit_hit);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_RESYNC;
            hold_q        <= HOLD_INIT;
            fault_flags_q <= 3'b000;
            err_count_q   <= 8'd0;
            core_rst_n_q  <= 1'b0;
            for (int i = 0; i < 3; i++) miss_cnt_q[i] <= 4'd0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            fault_flags_q <= fault_flags_d;
            err_count_q   <= err_count_d;
            core_rst_n_q  <= core_rst_n_d;
            for (int i = 0; i < 3; i++) miss_cnt_q[i] <= miss_cnt_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (trigger) state_d = ST_RESYNC;
            ST_RESYNC: if (hold_q == 8'd0) state_d = ST_RUN;
            default:   state_d = ST_RESYNC;
        endcase
    end

    always_comb begin
        hold_d        = hold_q;
        fault_flags_d = fault_flags_q;
        err_count_d   = err_count_q;
        for (int i = 0; i < 3; i++) miss_cnt_d[i] = 4'd0;
        if (state_q == ST_RUN) begin
            if (trigger) begin
                hold_d        = HOLD_INIT;
                fault_flags_d = fault_flags_q | (no_majority ? 3'b111 : limit_hit);
                err_count_d   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            end else begin
                for (int i = 0; i < 3; i++)
                    miss_cnt_d[i] = lane_mis[i] ? miss_cnt_q[i] + 4'd1 : 4'd0;
            end
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
        end
        // The core reset releases on the same edge that returns the FSM to RUN.
        core_rst_n_d = (state_d == ST_RUN);
    end

    always_comb begin
        mem_we      = vote_we && (state_q == ST_RUN) && !no_majority;
        resync      = (state_q == ST_RESYNC);
        core_rst_n  = core_rst_n_q;
        fault_flags = fault_flags_q;
        err_count   = err_count_q;
    end

endmodule

// File: tb/tb_tmr_lockstep_controller.sv
// Randomised self-checking bench for tmr_lockstep_controller against a
// behavioural model of the voting and restart rules.
module tb_tmr_lockstep_controller;

    localparam int FL = 3;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] pc [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic        we [3];
    logic        mem_we, core_rst_n, resync, no_majority;
    logic [31:0] mem_addr, mem_wdata, pc_voted;
    logic [2:0]  fault_flags;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Model state: cycles of core reset still to go (0 = running).
    int          m_left;
    int          m_miss [3];
    logic [2:0]  m_flags;
    int          m_err;

    tmr_lockstep_controller #(.FAULT_LIMIT(FL), .RESYNC_CYCLES(RC)) dut (
        .clk(clk), .rst_in(rst_in),
        .pc_a(pc[0]), .pc_b(pc[1]), .pc_c(pc[2]),
        .memwrite_a(we[0]), .memwrite_b(we[1]), .memwrite_c(we[2]),
        .addr_a(addr[0]), .addr_b(addr[1]), .addr_c(addr[2]),
        .wdata_a(wdata[0]), .wdata_b(wdata[1]), .wdata_c(wdata[2]),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc_voted(pc_voted), .core_rst_n(core_rst_n), .resync(resync),
        .no_majority(no_majority), .fault_flags(fault_flags), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vote32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
        return r;
    endfunction

    function automatic logic vote_store();
        return (int'(we[0]) + int'(we[1]) + int'(we[2])) >= 2;
    endfunction

    function automatic logic [96:0] lane_vector(input int i);
        return {pc[i], we[i], addr[i], vote_store() ? wdata[i] : 32'h0};
    endfunction

    function automatic logic [96:0] majority_vector();
        return {vote32(pc[0], pc[1], pc[2]), vote_store(), vote32(addr[0], addr[1], addr[2]),
                vote_store() ? vote32(wdata[0], wdata[1], wdata[2]) : 32'h0};
    endfunction

    function automatic logic model_nomaj();
        return lane_vector(0) != lane_vector(1) && lane_vector(0) != lane_vector(2) &&
               lane_vector(1) != lane_vector(2);
    endfunction

    function automatic logic [110:0] exp_bundle();
        logic running;
        running = (m_left == 0) && rst_in;
        return {vote_store() && running && !model_nomaj(), vote32(addr[0], addr[1], addr[2]),
                vote32(wdata[0], wdata[1], wdata[2]), vote32(pc[0], pc[1], pc[2]),
                running, !running, model_nomaj(), m_flags, 8'(m_err)};
    endfunction

    function automatic logic [110:0] act_bundle();
        return {mem_we, mem_addr, mem_wdata, pc_voted, core_rst_n, resync, no_majority, fault_flags, err_count};
    endfunction

    task automatic model_reset();
        m_left = RC; m_flags = 3'b000; m_err = 0;
        for (int i = 0; i < 3; i++) m_miss[i] = 0;
    endtask

    task automatic model_advance();
        logic [2:0] hit;
        logic nm;
        if (!rst_in) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
            for (int i = 0; i < 3; i++) m_miss[i] = 0;
        end else begin
            nm = model_nomaj();
            for (int i = 0; i < 3; i++)
                hit[i] = (lane_vector(i) != majority_vector()) && (m_miss[i] + 1 == FL);
            if (nm || hit != 3'b000) begin
                m_left = RC;
                m_flags |= nm ? 3'b111 : hit;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                for (int i = 0; i < 3; i++) m_miss[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++)
                    m_miss[i] = (lane_vector(i) != majority_vector()) ? m_miss[i] + 1 : 0;
            end
        end
    endtask

    // Test code lives at posedge+1; outputs are examined two units later.
    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive_all(input logic [31:0] p, input logic w, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            pc[i] = p; we[i] = w; addr[i] = a; wdata[i] = d;
        end
    endtask

    task automatic wait_run();
        int n = 0;
        drive_all(32'h0000_1000, 1'b0, 32'h0, 32'h0);
        while (core_rst_n !== 1'b1 && n < 40) begin
            tick(); n++;
        end
        checks++;
        if (core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL wait_run: core_rst_n %b after %0d cycles, required 1", core_rst_n, n);
        end
    endtask

    task automatic test_reset();
        drive_all(32'h0000_0040, 1'b1, 32'h0000_0100, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if ({core_rst_n, resync, mem_we, err_count, fault_flags} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'b000}) begin
                errors++;
                $display("FAIL reset_hold: rst_n/resync/we/err/flags=%b/%b/%b/%0d/%b required 0/1/0/0/000",
                         core_rst_n, resync, mem_we, err_count, fault_flags);
            end
            tick();
        end
        rst_in = 1'b1;
        for (int i = 0; i <= RC; i++) begin
            settle();
            checks++;
            if ({core_rst_n, resync, mem_we, err_count} !== {i == RC, i != RC, i == RC, 8'd0}) begin
                errors++;
                $display("FAIL reset_release[%0d]: rst_n/resync/we/err=%b/%b/%b/%0d required %b/%b/%b/0",
                         i, core_rst_n, resync, mem_we, err_count, i == RC, i != RC, i == RC);
            end
            if (i != RC) tick();
        end
        $display("reset: core_rst_n high after %0d edges", RC);
    endtask

    task automatic test_lockstep_store();
        drive_all(32'h0000_0200, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        settle();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, fault_flags, no_majority} !== {1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL lockstep_store: we=%b addr=%h wdata=%h flags=%b nm=%b required 1/00000100/deadbeef/000/0",
                     mem_we, mem_addr, mem_wdata, fault_flags, no_majority);
        end
        tick();
        $display("lockstep_store: addr=%h wdata=%h we=%b", mem_addr, mem_wdata, mem_we);
    endtask

    task automatic test_transient_fault();
        for (int c = 0; c < 5; c++) begin
            drive_all(32'h0000_0300 + 32'(c * 4), 1'b0, 32'h0, 32'h0);
            if (c < 2) pc[1] = pc[1] ^ 32'h8;
            settle();
            checks++;
            if ({pc_voted, core_rst_n, fault_flags} !== {32'h0000_0300 + 32'(c * 4), 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL transient[%0d]: pc=%h rst_n=%b flags=%b required %h/1/000",
                         c, pc_voted, core_rst_n, fault_flags, 32'h0000_0300 + 32'(c * 4));
            end
            tick();
        end
        $display("transient: no restart, flags=%b", fault_flags);
    endtask

    task automatic test_persistent_fault();
        for (int c = 0; c < 3; c++) begin
            drive_all(32'h0000_0400 + 32'(c * 4), 1'b1, 32'h0000_0800, 32'hCAFE_0000 + 32'(c));
            wdata[2] = 32'h0BAD_0000 + 32'(c);
            settle();
            checks++;
            if ({mem_we, mem_wdata, resync} !== {1'b1, 32'hCAFE_0000 + 32'(c), 1'b0}) begin
                errors++;
                $display("FAIL persistent[%0d]: we=%b wdata=%h resync=%b required 1/%h/0",
                         c, mem_we, mem_wdata, resync, 32'hCAFE_0000 + 32'(c));
            end
            tick();
        end
        settle();
        checks++;
        if ({resync, core_rst_n, fault_flags, err_count} !== {1'b1, 1'b0, 3'b100, 8'd1}) begin
            errors++;
            $display("FAIL persistent_restart: resync=%b rst_n=%b flags=%b err=%0d required 1/0/100/1",
                     resync, core_rst_n, fault_flags, err_count);
        end
        $display("persistent: flags=%b err_count=%0d", fault_flags, err_count);
        wait_run();
    endtask

    task automatic test_triple_disagreement();
        drive_all(32'h0000_0500, 1'b1, 32'h0, 32'h5555_AAAA);
        addr[0] = 32'd1; addr[1] = 32'd2; addr[2] = 32'd4;
        settle();
        checks++;
        if ({no_majority, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL triple_cycle: no_majority=%b mem_we=%b required 1/0", no_majority, mem_we);
        end
        tick();
        settle();
        checks++;
        if ({core_rst_n, fault_flags, err_count} !== {1'b0, 3'b111, 8'd2}) begin
            errors++;
            $display("FAIL triple_next: rst_n=%b flags=%b err=%0d required 0/111/2", core_rst_n, fault_flags, err_count);
        end
        $display("triple: flags=%b err_count=%0d", fault_flags, err_count);
        wait_run();
    endtask

    task automatic test_random();
        logic [110:0] a, e;
        for (int c = 0; c < 400; c++) begin
            drive_all($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 3))
                        0: pc[i][$urandom_range(0, 31)] ^= 1'b1;
                        1: we[i] = ~we[i];
                        2: addr[i][$urandom_range(0, 31)] ^= 1'b1;
                        default: wdata[i][$urandom_range(0, 31)] ^= 1'b1;
                    endcase
                end
            end
            settle();
            a = act_bundle(); e = exp_bundle();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL random[%0d]: outputs %h required %h", c, a, e);
            end
            tick();
        end
        $display("random: 400 cycles, err_count=%0d flags=%b", err_count, fault_flags);
    endtask

    task automatic test_saturation_and_reset();
        for (int n = 0; n < 256; n++) begin
            drive_all(32'h0000_0600, 1'b1, 32'h0, 32'h0);
            addr[0] = 32'd1; addr[1] = 32'd2; addr[2] = 32'd4;
            tick();
            wait_run();
        end
        settle();
        checks++;
        if ({err_count, 8'(m_err)} !== {8'd255, 8'd255}) begin
            errors++;
            $display("FAIL saturation: err_count=%0d model=%0d required 255", err_count, m_err);
        end
        drive_all(32'h0000_0700, 1'b1, 32'h0, 32'h0);
        addr[0] = 32'd8; addr[1] = 32'd16; addr[2] = 32'd32;
        tick();
        drive_all(32'h0000_0700, 1'b0, 32'h0, 32'h0);
        tick();
        rst_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({fault_flags, err_count, core_rst_n, resync, mem_we} !== {3'b000, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: flags=%b err=%0d rst_n=%b resync=%b we=%b required 000/0/0/1/0",
                     fault_flags, err_count, core_rst_n, resync, mem_we);
        end
        #1;
        tick();
        rst_in = 1'b1;
        wait_run();
        $display("saturation: err_count held at 255, async reset cleared status");
    endtask

    initial begin
        drive_all(32'h0, 1'b0, 32'h0, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_lockstep_store();
        test_transient_fault();
        test_persistent_fault();
        test_triple_disagreement();
        test_random();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
